// File: rtl/noc_rx_framer.sv
// Receive-side framer: validates head/body/tail sequencing of NoC flits and forwards them one cycle later.
// Optional statistics counters (pkt_cnt, err_cnt) are built when NOC_RX_FRAMER_STAT_EN is defined.
module noc_rx_framer #(
  parameter int BODY_LEN   = 16,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic [DATA_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  buffer_busy,
  output logic [DATA_WIDTH:0]   noc2axi_data,
  output logic                  s_is_head,
  output logic                  s_is_tail,
  output logic                  proto_err
`ifdef NOC_RX_FRAMER_STAT_EN
  ,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           err_cnt
`endif
);

  localparam logic [3:0] KIND_HEAD = 4'hA;
  localparam logic [3:0] KIND_TAIL = 4'hF;
  localparam logic [7:0] LAST_BODY = 8'(BODY_LEN - 1);

  typedef enum logic [1:0] {IDLE, BODY, TAIL} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH:0] data_q, data_d;
  logic                head_q, head_d;
  logic                tail_q, tail_d;
  logic                err_q, err_d;
  logic                accept;
  logic [3:0]          kind;

  assign in_ready = ~buffer_busy & ~noc_rst;
  assign accept   = in_valid & in_ready;
  assign kind     = in_flit[56:53];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = '0;
    head_d  = 1'b0;
    tail_d  = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (kind == KIND_HEAD) begin
            state_d = BODY;
            cnt_d   = '0;
            data_d  = {1'b1, in_flit};
            head_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        BODY: begin
          // Body kind is never decoded; only the count decides where the tail sits.
          data_d = {1'b1, in_flit};
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == LAST_BODY) state_d = TAIL;
        end
        TAIL: begin
          data_d  = {1'b1, in_flit};
          tail_d  = 1'b1;
          err_d   = (kind != KIND_TAIL);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      err_q   <= err_d;
    end
  end

  assign noc2axi_data = data_q;
  assign s_is_head    = head_q;
  assign s_is_tail    = tail_q;
  assign proto_err    = err_q;

`ifdef NOC_RX_FRAMER_STAT_EN
  logic [15:0] pkt_cnt_q, err_cnt_q;

  // Counters saturate rather than wrap so long soaks never report a small value.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (tail_d && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (err_d && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/noc_rx_framer.md
NOC_RX_FRAMER -- requirements
Module: noc_rx_framer

Interface
REQ-001 Parameter BODY_LEN, default 16: body flits per packet, range 1..255.
REQ-002 Parameter DATA_WIDTH, default 128: flit payload width; the field positions in REQ-012 are fixed for 128.
REQ-003 noc_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 noc_rst  input  1  synchronous, active-high reset.
REQ-005 in_flit  input  DATA_WIDTH  raw flit from the router port.
REQ-006 in_valid  input  1  in_flit valid.
REQ-007 in_ready  output  1  flit accepted when in_valid and in_ready are both high in the same cycle.
REQ-008 buffer_busy  input  1  downstream noc2axi stage cannot take flits.
REQ-009 noc2axi_data  output  DATA_WIDTH+1  {valid bit, payload} to the downstream noc2axi stage.
REQ-010 s_is_head / s_is_tail  output  1 each  marks the head or tail flit on noc2axi_data.
REQ-011 proto_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-012 Head/tail flit fields:
  - [127:124] pkt_type
  - [123:120] src_id
  - [119:116] dst_id
  - [115:113] size
  - [112:97] len
  - [96:57] addr
  - [56:53] kind (4'hA = head, 4'hF = tail)
  - [2:0] vc
REQ-013 in_ready shall equal ~buffer_busy combinationally; it is forced to 0 while noc_rst is high.
REQ-014 FSM states and transitions:
  - IDLE -> BODY on an accepted flit with kind == 4'hA.
  - BODY -> TAIL on the BODY_LEN-th accepted flit.
  - TAIL -> IDLE on the next accepted flit.
REQ-015 In IDLE, an accepted flit with kind != 4'hA shall be dropped: noc2axi_data stays 0, proto_err pulses, state remains IDLE.
REQ-016 In BODY, the kind field shall not be decoded; every accepted flit is forwarded as body data.
REQ-017 In TAIL, an accepted flit shall always be forwarded with s_is_tail=1; if its kind != 4'hF, proto_err also pulses.
REQ-018 Forwarding latency is exactly 1 cycle. The registered outputs are:
  - noc2axi_data = {1'b1, in_flit};
  - s_is_head = 1 for the flit accepted in IDLE;
  - s_is_tail = 1 for the flit accepted in TAIL.
REQ-019 In any cycle with no accepted flit, noc2axi_data, s_is_head and s_is_tail shall all register to 0.
REQ-020 The body counter is 8 bits, cleared on head acceptance and incremented per accepted body flit; it shall not wrap within a packet.
REQ-021 Assertion of buffer_busy mid-packet shall stall the packet without losing state or counter value; acceptance resumes at the same position.
REQ-022 A head flit may be accepted in the cycle immediately after a tail flit, giving back-to-back packets with no idle cycle.

Reset
REQ-023 While noc_rst is high at a clock edge, the following shall clear:
  - FSM to IDLE;
  - body counter to 0;
  - noc2axi_data to 0;
  - s_is_head, s_is_tail and proto_err to 0.
REQ-024 Reset asserted mid-packet shall abandon the packet; the first flit after reset must be a head, otherwise REQ-015 applies.

Configuration
REQ-025 With macro NOC_RX_FRAMER_STAT_EN defined, the block adds two outputs:
  - pkt_cnt[15:0]: increments on each forwarded tail flit;
  - err_cnt[15:0]: increments on each proto_err pulse.
  Both counters saturate at 16'hFFFF and reset to 0.
REQ-026 Without NOC_RX_FRAMER_STAT_EN, those ports and counters shall not exist; all other behaviour is identical.

Verification
REQ-027 Head (kind=A, len=16'h0002), body flits 1..16, then tail (kind=F), all with buffer_busy=0 -> the following cycle carries s_is_head=1; the 16 body flits appear with valid=1 and payloads 1..16; then s_is_tail=1; proto_err stays 0.
REQ-028 Two packets back-to-back with no gap -> the second s_is_head appears in the cycle directly after the first s_is_tail; 36 consecutive valid output cycles.
REQ-029 buffer_busy=1 for 5 cycles after body flit 7 -> in_ready=0 for those 5 cycles; the output resumes with payload 8; the tail still arrives after payload 16.
REQ-030 Body flit (kind=0) presented in IDLE -> dropped, proto_err pulses once, and a following valid head is forwarded normally; with STAT_EN, err_cnt=1.
REQ-031 Tail position carries kind=4'h3 -> s_is_tail=1 with proto_err=1 in the same cycle; FSM returns to IDLE.
REQ-032 noc_rst pulsed after body flit 5 -> all outputs 0 the next cycle; a fresh head then produces s_is_head=1; with STAT_EN, pkt_cnt=0 afterwards.
